// File: rtl/data_mem_responder.sv
// Data-port memory responder: combinational 32-bit reads and byte-masked 64-bit line writes.
// After reset the array is swept to zero before ready rises; out-of-range accesses raise a sticky err.
module data_mem_responder #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] addr,
    input  logic        wr_en,
    input  logic [63:0] wdata,
    input  logic [7:0]  wmask,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int unsigned LW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 3;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   clr_idx_q, clr_idx_d;
    logic            err_q, err_d;
    logic [63:0]     mem [DEPTH];

    logic [31:0]     off;
    logic            in_range;
    logic [LW-1:0]   line;
    logic            half;

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign off      = addr - BASE_ADDR;
    assign in_range = {1'b0, off} < SPAN;
    assign line     = off[LW+2:3];
    assign half     = off[2];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        err_d     = err_q;
        case (state_q)
            S_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LW'(DEPTH - 1))
                    state_d = S_RUN;
            end
            S_RUN: begin
                // Every RUN cycle is either a write or a read, so any out-of-range address counts.
                if (!in_range)
                    err_d = 1'b1;
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        ready = (state_q == S_RUN);
        err   = err_q;
        rdata = 32'h0;
        if (state_q == S_RUN && in_range)
            rdata = half ? mem[line][63:32] : mem[line][31:0];
    end

    // Array has no reset of its own; the CLEAR sweep owns the write port until RUN.
    always_ff @(posedge clk) begin
        if (nrst && state_q == S_CLEAR) begin
            mem[clr_idx_q] <= 64'h0;
        end else if (nrst && state_q == S_RUN && wr_en && in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (wmask[i])
                    mem[line][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (default map, and DEPTH=16 at BASE 0x1000) checked
// every cycle against a line-array model, plus literal checks of the documented scenarios.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        nrst_s  [2];
    logic [31:0] addr_s  [2];
    logic        wr_en_s [2];
    logic [63:0] wdata_s [2];
    logic [7:0]  wmask_s [2];
    logic [31:0] rdata_s [2];
    logic        ready_s [2];
    logic        err_s   [2];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(256), .BASE_ADDR(32'h0)) dut_a (
        .clk(clk), .nrst(nrst_s[0]), .addr(addr_s[0]), .wr_en(wr_en_s[0]),
        .wdata(wdata_s[0]), .wmask(wmask_s[0]), .rdata(rdata_s[0]),
        .ready(ready_s[0]), .err(err_s[0]));

    data_mem_responder #(.DEPTH(16), .BASE_ADDR(32'h1000)) dut_b (
        .clk(clk), .nrst(nrst_s[1]), .addr(addr_s[1]), .wr_en(wr_en_s[1]),
        .wdata(wdata_s[1]), .wmask(wmask_s[1]), .rdata(rdata_s[1]),
        .ready(ready_s[1]), .err(err_s[1]));

    // Model: per instance, count of released edges since reset, sticky error, and line contents.
    int unsigned dep  [2] = '{256, 16};
    logic [31:0] base [2] = '{32'h0, 32'h1000};
    int unsigned cnt  [2];
    logic        err_m[2];
    logic [63:0] mm   [2][256];
    bit          armed = 0;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s[%0d] got %h expected %h at %0t", nm, i, act, exp, $time);
        else
            passed++;
    endtask

    function automatic logic [31:0] exp_rdata(input int i);
        logic [31:0] off;
        logic [63:0] w;
        off = addr_s[i] - base[i];
        if (cnt[i] < dep[i] || off >= dep[i] * 8) return 32'h0;
        w = mm[i][off >> 3];
        return off[2] ? w[63:32] : w[31:0];
    endfunction

    task automatic model_edge(input int i);
        logic [31:0] off;
        off = addr_s[i] - base[i];
        if (!nrst_s[i]) begin
            cnt[i]   = 0;
            err_m[i] = 1'b0;
            for (int j = 0; j < 256; j++) mm[i][j] = 64'h0;
        end else if (cnt[i] < dep[i]) begin
            cnt[i]++;
        end else if (off >= dep[i] * 8) begin
            err_m[i] = 1'b1;
        end else if (wr_en_s[i]) begin
            for (int b = 0; b < 8; b++)
                if (wmask_s[i][b]) mm[i][off >> 3][8*b +: 8] = wdata_s[i][8*b +: 8];
        end
    endtask

    // One cycle: compare both instances mid-cycle, then advance the model on the edge.
    task automatic tick();
        @(negedge clk);
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                chk("ready", i, 64'(ready_s[i]), 64'(cnt[i] >= dep[i]));
                chk("err",   i, 64'(err_s[i]),   64'(err_m[i]));
                chk("rdata", i, 64'(rdata_s[i]), 64'(exp_rdata(i)));
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i);
        armed = 1;
        #1;
    endtask

    task automatic idle(input int i);
        addr_s[i]  = base[i];
        wr_en_s[i] = 1'b0;
        wmask_s[i] = 8'h0;
    endtask

    task automatic rd(input int i, input logic [31:0] a, input logic [31:0] exp, input string nm);
        addr_s[i]  = a;
        wr_en_s[i] = 1'b0;
        #1;
        chk(nm, i, 64'(rdata_s[i]), 64'(exp));
    endtask

    task automatic wr(input int i, input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
        addr_s[i]  = a;
        wr_en_s[i] = 1'b1;
        wdata_s[i] = d;
        wmask_s[i] = m;
        tick();
        idle(i);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            nrst_s[i]  = 1'b0;
            wdata_s[i] = 64'h0;
            idle(i);
        end

        // Reset both for two cycles, then time the sweep on the 256-line instance.
        tick();
        tick();
        nrst_s[0] = 1'b1;
        nrst_s[1] = 1'b1;
        for (int k = 0; k < 255; k++) tick();
        chk("ready_after_255", 0, 64'(ready_s[0]), 64'h0);
        tick();
        chk("ready_after_256", 0, 64'(ready_s[0]), 64'h1);
        chk("err_after_reset", 0, 64'(err_s[0]), 64'h0);
        rd(0, 32'h0,   32'h0, "clear_rd_0");
        rd(0, 32'h7FC, 32'h0, "clear_rd_7fc");
        idle(0);

        // Full-mask write, then a low-half partial write.
        wr(0, 32'h10, 64'h1122334455667788, 8'hFF);
        rd(0, 32'h10, 32'h55667788, "full_lo");
        rd(0, 32'h14, 32'h11223344, "full_hi");
        wr(0, 32'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        rd(0, 32'h10, 32'hAAAAAAAA, "part_lo");
        rd(0, 32'h14, 32'h11223344, "part_hi");
        idle(0);

        // Offset base: write and read back through BASE_ADDR=0x1000.
        wr(1, 32'h1008, 64'hCAFEF00D_DEADBEEF, 8'hFF);
        rd(1, 32'h1008, 32'hDEADBEEF, "base_rd");
        rd(1, 32'h100C, 32'hCAFEF00D, "base_rd_hi");
        idle(1);

        // Random in-range traffic; instance A avoids line 0 so the alias check below stays literal.
        for (int k = 0; k < 400; k++) begin
            addr_s[0]  = 32'h8 + $urandom_range(0, 2039);
            wr_en_s[0] = $urandom_range(0, 1) == 1;
            wdata_s[0] = {$urandom, $urandom};
            wmask_s[0] = 8'($urandom);
            addr_s[1]  = 32'h1000 + $urandom_range(0, 127);
            wr_en_s[1] = $urandom_range(0, 1) == 1;
            wdata_s[1] = {$urandom, $urandom};
            wmask_s[1] = 8'($urandom);
            tick();
        end
        idle(0);
        idle(1);
        tick();

        // Out-of-range write aliasing line 0 must not land, and err must stick.
        wr(0, 32'h800, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        chk("oor_err", 0, 64'(err_s[0]), 64'h1);
        rd(0, 32'h0, 32'h0, "alias_lo");
        rd(0, 32'h4, 32'h0, "alias_hi");
        wr(0, 32'h20, 64'h0123456789ABCDEF, 8'hFF);
        tick();
        chk("err_sticky", 0, 64'(err_s[0]), 64'h1);

        // Out-of-range read below the base on instance B.
        chk("b_err_before", 1, 64'(err_s[1]), 64'h0);
        addr_s[1] = 32'h0FFC;
        tick();
        idle(1);
        tick();
        chk("b_err_below_base", 1, 64'(err_s[1]), 64'h1);

        // Reset mid-sweep restarts the full clear.
        nrst_s[0] = 1'b0;
        tick();
        nrst_s[0] = 1'b1;
        for (int k = 0; k < 100; k++) tick();
        nrst_s[0] = 1'b0;
        tick();
        nrst_s[0] = 1'b1;
        chk("err_cleared", 0, 64'(err_s[0]), 64'h0);
        for (int k = 0; k < 255; k++) tick();
        chk("restart_ready_255", 0, 64'(ready_s[0]), 64'h0);
        tick();
        chk("restart_ready_256", 0, 64'(ready_s[0]), 64'h1);
        rd(0, 32'h10, 32'h0, "restart_rd_10");
        rd(0, 32'h14, 32'h0, "restart_rd_14");
        idle(0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
